// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the sphere-box collision datapath float-compare arbiters.
// Latency: none, declarations only.
// Backpressure: not applicable; holds the state encoding, float width and default WAIT timeout.
package fp_cmp_pkg;

  localparam int FP_W        = 32;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CRST   = 3'd1,
    SEND_A = 3'd2,
    SEND_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

endpackage

// File: rtl/fp_cmp_arbiter_if.sv
// Requester and comparator-side bus of the shared float comparator arbiter.
// Latency: none, wiring only.
// Backpressure: stb/ack on every channel; master is the arbiter, slave is requesters plus comparator.
interface fp_cmp_arbiter_if
  import fp_cmp_pkg::*;
#(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]      req_stb;
  logic [FP_W*N_REQ-1:0] req_a;
  logic [FP_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]      req_ack;
  logic [N_REQ-1:0]      rsp_stb;
  logic [N_REQ-1:0]      rsp_ack;
  logic                  rsp_z;
  logic                  rsp_err;
  logic                  cmp_rst;
  logic [FP_W-1:0]       cmp_a;
  logic [FP_W-1:0]       cmp_b;
  logic                  cmp_a_stb;
  logic                  cmp_b_stb;
  logic                  cmp_a_ack;
  logic                  cmp_b_ack;
  logic                  cmp_z;
  logic                  cmp_z_stb;
  logic                  cmp_z_ack;

  modport master (
    input  req_stb, req_a, req_b, rsp_ack, cmp_a_ack, cmp_b_ack, cmp_z, cmp_z_stb,
    output req_ack, rsp_stb, rsp_z, rsp_err, cmp_rst, cmp_a, cmp_b, cmp_a_stb, cmp_b_stb, cmp_z_ack
  );

  modport slave (
    output req_stb, req_a, req_b, rsp_ack, cmp_a_ack, cmp_b_ack, cmp_z, cmp_z_stb,
    input  req_ack, rsp_stb, rsp_z, rsp_err, cmp_rst, cmp_a, cmp_b, cmp_a_stb, cmp_b_stb, cmp_z_ack
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after last_grant+1 (mod N_REQ) with req set.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    grant,
  output logic             any_req
);

  logic [GW:0] sum;

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    grant = last_grant;
    sum   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      sum = {1'b0, last_grant} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      if (req[sum[GW-1:0]]) grant = sum[GW-1:0];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Shares one one-shot float comparator among N_REQ requesters, round-robin, re-arming it per op.
// Latency: grant to rsp_stb = 4 + comparator result latency (TIMEOUT+4 when it never answers).
// Backpressure: one op in flight; rsp_stb held until rsp_ack, new requests wait in req_stb.
module fp_cmp_arbiter
  import fp_cmp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GW      = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst,
  fp_cmp_arbiter_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    gnt;
  logic [GW-1:0]    pick_idx;
  logic             pick_any;
  logic [FP_W-1:0]  op_a;
  logic [FP_W-1:0]  op_b;
  logic [CW-1:0]    wait_cnt;
  logic [N_REQ-1:0] req_ack_q;
  logic [N_REQ-1:0] rsp_stb_q;
  logic             rsp_z_q;
  logic             rsp_err_q;
  logic             cmp_a_stb_q;
  logic             cmp_b_stb_q;

  rr_pick #(
    .N_REQ(N_REQ),
    .GW   (GW)
  ) u_pick (
    .req       (bus.req_stb),
    .last_grant(last_grant),
    .grant     (pick_idx),
    .any_req   (pick_any)
  );

  // Transaction sequencer: grant, re-arm comparator, send A then B, await result, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= GW'(N_REQ - 1);
      gnt         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      wait_cnt    <= '0;
      req_ack_q   <= '0;
      rsp_stb_q   <= '0;
      rsp_z_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      cmp_a_stb_q <= 1'b0;
      cmp_b_stb_q <= 1'b0;
    end else begin
      req_ack_q <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt       <= pick_idx;
            op_a      <= bus.req_a[int'(pick_idx)*FP_W +: FP_W];
            op_b      <= bus.req_b[int'(pick_idx)*FP_W +: FP_W];
            req_ack_q <= N_REQ'(1) << pick_idx;
            state     <= CRST;
          end
        end
        CRST: begin
          cmp_a_stb_q <= 1'b1;
          state       <= SEND_A;
        end
        SEND_A: begin
          if (cmp_a_stb_q && bus.cmp_a_ack) begin
            cmp_a_stb_q <= 1'b0;
            cmp_b_stb_q <= 1'b1;
            state       <= SEND_B;
          end
        end
        SEND_B: begin
          if (cmp_b_stb_q && bus.cmp_b_ack) begin
            cmp_b_stb_q <= 1'b0;
            wait_cnt    <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // A real result beats a timeout landing on the same cycle.
          if (bus.cmp_z_stb) begin
            rsp_z_q   <= bus.cmp_z;
            rsp_err_q <= 1'b0;
            rsp_stb_q <= N_REQ'(1) << gnt;
            state     <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT)) begin
            rsp_z_q   <= 1'b0;
            rsp_err_q <= 1'b1;
            rsp_stb_q <= N_REQ'(1) << gnt;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ack[gnt]) begin
            rsp_stb_q  <= '0;
            last_grant <= gnt;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ack   = req_ack_q;
  assign bus.rsp_stb   = rsp_stb_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.cmp_a     = op_a;
  assign bus.cmp_b     = op_b;
  assign bus.cmp_a_stb = cmp_a_stb_q;
  assign bus.cmp_b_stb = cmp_b_stb_q;
  assign bus.cmp_z_ack = 1'b1;
  // The comparator only clears its sticky result on its own reset.
  assign bus.cmp_rst   = rst | (state == CRST);

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Directed bench for fp_cmp_arbiter with a one-shot comparator model of fixed result latency.
// Latency: comparator model raises cmp_z_stb 3 cycles after accepting B.
// Backpressure: requesters ack responses automatically unless auto_ack is cleared.
module tb_fp_cmp_arbiter;
  import fp_cmp_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_cmp_arbiter_if #(.N_REQ(N)) bus ();

  fp_cmp_arbiter #(
    .N_REQ  (N),
    .GW     (2),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Comparator model: one-shot, sticky result until cmp_rst; for positive floats
  // less-than matches an unsigned compare of the bit patterns.
  logic [31:0] ma, mb;
  logic        mz, mz_stb, have_b;
  logic        hang = 1'b0;
  int          lat_cnt;

  assign bus.cmp_a_ack = 1'b1;
  assign bus.cmp_b_ack = 1'b1;
  assign bus.cmp_z     = mz;
  assign bus.cmp_z_stb = mz_stb;

  // Comparator behaviour
  always @(posedge clk) begin
    if (bus.cmp_rst) begin
      mz_stb  <= 1'b0;
      mz      <= 1'b0;
      have_b  <= 1'b0;
      lat_cnt <= 0;
    end else begin
      if (bus.cmp_a_stb) ma <= bus.cmp_a;
      if (bus.cmp_b_stb) begin
        mb      <= bus.cmp_b;
        have_b  <= 1'b1;
        lat_cnt <= 1;
      end else if (have_b && !mz_stb && !hang) begin
        if (lat_cnt >= LAT) begin
          mz_stb <= 1'b1;
          mz     <= (ma < mb);
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int crst_cnt = 0;
  int ack_multi = 0;
  int rsp_multi = 0;
  logic [N-1:0] hold_mask = '0;
  logic [N-1:0] prev_rsp  = '0;
  logic auto_ack = 1'b1;
  int   gnt_q[$];
  int   gnt_cyc_q[$];
  int   rsp_idx_q[$];
  int   rsp_cyc_q[$];
  logic rsp_z_q[$];
  logic rsp_err_q[$];

  task automatic clear_logs();
    gnt_q.delete(); gnt_cyc_q.delete(); rsp_idx_q.delete(); rsp_cyc_q.delete();
    rsp_z_q.delete(); rsp_err_q.delete();
    crst_cnt = 0; ack_multi = 0; rsp_multi = 0;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  // One clock: observe outputs 1 time unit after the edge, play requester roles.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.cmp_rst && !rst) crst_cnt++;
    if (bus.req_ack != '0) begin
      if (!$onehot(bus.req_ack)) ack_multi++;
      for (int i = 0; i < N; i++) begin
        if (bus.req_ack[i]) begin
          gnt_q.push_back(i);
          gnt_cyc_q.push_back(cyc);
          if (!hold_mask[i]) bus.req_stb[i] = 1'b0;
        end
      end
    end
    if (bus.rsp_stb != '0 && prev_rsp == '0) begin
      if (!$onehot(bus.rsp_stb)) rsp_multi++;
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.rsp_stb[i]) begin
          rsp_idx_q.push_back(i);
        end
      end
      rsp_z_q.push_back(bus.rsp_z);
      rsp_err_q.push_back(bus.rsp_err);
      rsp_cyc_q.push_back(cyc);
    end
    prev_rsp    = bus.rsp_stb;
    bus.rsp_ack = auto_ack ? bus.rsp_stb : '0;
  endtask

  task automatic run_until_rsp(input int n, input int bound);
    for (int i = 0; i < bound && rsp_idx_q.size() < n; i++) step();
  endtask

  task automatic do_reset();
    bus.req_stb = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.cmp_rst !== 1'b1) begin failures++; $display("FAIL reset_cmp_rst got=%b exp=1", bus.cmp_rst); end
    checks++; if (bus.req_ack !== 4'b0) begin failures++; $display("FAIL reset_req_ack got=%b exp=0000", bus.req_ack); end
    checks++; if (bus.rsp_stb !== 4'b0) begin failures++; $display("FAIL reset_rsp_stb got=%b exp=0000", bus.rsp_stb); end
    checks++; if ({bus.cmp_a_stb, bus.cmp_b_stb} !== 2'b00) begin failures++; $display("FAIL reset_cmp_stb got=%b%b exp=00", bus.cmp_a_stb, bus.cmp_b_stb); end
    checks++; if ({bus.rsp_z, bus.rsp_err} !== 2'b00) begin failures++; $display("FAIL reset_rsp_z_err got=%b%b exp=00", bus.rsp_z, bus.rsp_err); end
    checks++; if (bus.cmp_z_ack !== 1'b1) begin failures++; $display("FAIL reset_cmp_z_ack got=%b exp=1", bus.cmp_z_ack); end
    rst = 1'b0;
    #1;
    checks++; if (bus.cmp_rst !== 1'b0) begin failures++; $display("FAIL reset_cmp_rst_release got=%b exp=0", bus.cmp_rst); end
    step();
    clear_logs();
  endtask

  task automatic test_single();
    int t0;
    clear_logs();
    set_op(0, 32'h3F800000, 32'h40000000);
    t0 = cyc;
    bus.req_stb[0] = 1'b1;
    run_until_rsp(1, 40);
    step(); step();
    checks++;
    if (rsp_idx_q.size() != 1 || gnt_q.size() != 1) begin
      failures++; $display("FAIL single_count rsp=%0d gnt=%0d exp=1/1", rsp_idx_q.size(), gnt_q.size());
    end else begin
      checks++; if (gnt_q[0] !== 0) begin failures++; $display("FAIL single_grant got=%0d exp=0", gnt_q[0]); end
      checks++; if ((gnt_cyc_q[0] - t0) !== 1) begin failures++; $display("FAIL single_ack_delay got=%0d exp=1", gnt_cyc_q[0] - t0); end
      checks++; if ((rsp_cyc_q[0] - gnt_cyc_q[0]) !== 4 + LAT) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", rsp_cyc_q[0] - gnt_cyc_q[0], 4 + LAT); end
      checks++; if (rsp_idx_q[0] !== 0) begin failures++; $display("FAIL single_rsp_idx got=%0d exp=0", rsp_idx_q[0]); end
      checks++; if ({rsp_z_q[0], rsp_err_q[0]} !== 2'b10) begin failures++; $display("FAIL single_z_err got=%b%b exp=10", rsp_z_q[0], rsp_err_q[0]); end
    end
    checks++; if (crst_cnt !== 1) begin failures++; $display("FAIL single_cmp_rst_pulses got=%0d exp=1", crst_cnt); end
    checks++; if (ma !== 32'h3F800000 || mb !== 32'h40000000) begin failures++; $display("FAIL single_operands got=%h/%h exp=3f800000/40000000", ma, mb); end
  endtask

  task automatic test_all_same_cycle();
    logic [3:0] exp_z;
    exp_z = 4'b0101;
    do_reset();
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40400000, 32'h3F800000);
    set_op(2, 32'h3F000000, 32'h3F400000);
    set_op(3, 32'h41200000, 32'h40A00000);
    bus.req_stb = 4'hF;
    run_until_rsp(4, 200);
    step(); step();
    checks++;
    if (rsp_idx_q.size() != 4 || gnt_q.size() != 4) begin
      failures++; $display("FAIL all_count rsp=%0d gnt=%0d exp=4/4", rsp_idx_q.size(), gnt_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gnt_q[k] !== k || rsp_idx_q[k] !== k) begin failures++; $display("FAIL all_order slot=%0d grant=%0d rsp=%0d exp=%0d", k, gnt_q[k], rsp_idx_q[k], k); end
        checks++; if (rsp_z_q[k] !== exp_z[k] || rsp_err_q[k] !== 1'b0) begin failures++; $display("FAIL all_result req=%0d z=%b err=%b exp=%b/0", k, rsp_z_q[k], rsp_err_q[k], exp_z[k]); end
        checks++; if ((rsp_cyc_q[k] - gnt_cyc_q[k]) !== 4 + LAT) begin failures++; $display("FAIL all_latency req=%0d got=%0d exp=%0d", k, rsp_cyc_q[k] - gnt_cyc_q[k], 4 + LAT); end
      end
    end
    checks++; if (ack_multi !== 0 || rsp_multi !== 0) begin failures++; $display("FAIL all_onehot ack_multi=%0d rsp_multi=%0d exp=0/0", ack_multi, rsp_multi); end
  endtask

  task automatic test_wrap();
    clear_logs();
    hold_mask   = 4'b1001;
    bus.req_stb = 4'b1001;
    run_until_rsp(4, 200);
    bus.req_stb = '0;
    hold_mask   = '0;
    repeat (12) step();
    checks++;
    if (gnt_q.size() != 4 || rsp_idx_q.size() != 4) begin
      failures++; $display("FAIL wrap_count gnt=%0d rsp=%0d exp=4/4", gnt_q.size(), rsp_idx_q.size());
    end else begin
      checks++; if (gnt_q[0] !== 0 || gnt_q[1] !== 3 || gnt_q[2] !== 0 || gnt_q[3] !== 3) begin failures++; $display("FAIL wrap_order got=%0d,%0d,%0d,%0d exp=0,3,0,3", gnt_q[0], gnt_q[1], gnt_q[2], gnt_q[3]); end
      checks++; if ({rsp_z_q[0], rsp_z_q[1], rsp_z_q[2], rsp_z_q[3]} !== 4'b1010) begin failures++; $display("FAIL wrap_results got=%b%b%b%b exp=1010", rsp_z_q[0], rsp_z_q[1], rsp_z_q[2], rsp_z_q[3]); end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    int hold_end;
    clear_logs();
    auto_ack = 1'b0;
    set_op(1, 32'h3F800000, 32'h40400000);
    bus.req_stb[1] = 1'b1;
    run_until_rsp(1, 40);
    set_op(2, 32'h3F000000, 32'h3F400000);
    bus.req_stb[2] = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (bus.rsp_stb !== 4'b0010 || bus.rsp_z !== 1'b1 || bus.rsp_err !== 1'b0) bad++;
    end
    hold_end = cyc;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable unstable_cycles=%0d exp=0", bad); end
    checks++; if (gnt_q.size() !== 1) begin failures++; $display("FAIL bp_no_new_grant grants=%0d exp=1", gnt_q.size()); end
    auto_ack = 1'b1;
    run_until_rsp(2, 40);
    step(); step();
    checks++;
    if (gnt_q.size() != 2 || rsp_idx_q.size() != 2) begin
      failures++; $display("FAIL bp_release_count gnt=%0d rsp=%0d exp=2/2", gnt_q.size(), rsp_idx_q.size());
    end else begin
      checks++; if (gnt_q[1] !== 2 || gnt_cyc_q[1] <= hold_end) begin failures++; $display("FAIL bp_next_grant got=%0d at=%0d exp=2 after %0d", gnt_q[1], gnt_cyc_q[1], hold_end); end
      checks++; if (rsp_idx_q[1] !== 2 || rsp_z_q[1] !== 1'b1 || rsp_err_q[1] !== 1'b0) begin failures++; $display("FAIL bp_next_rsp idx=%0d z=%b err=%b exp=2/1/0", rsp_idx_q[1], rsp_z_q[1], rsp_err_q[1]); end
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    hang = 1'b1;
    set_op(3, 32'h3F800000, 32'h40000000);
    bus.req_stb[3] = 1'b1;
    run_until_rsp(1, 400);
    hang = 1'b0;
    checks++;
    if (rsp_idx_q.size() != 1 || gnt_q.size() != 1) begin
      failures++; $display("FAIL timeout_count rsp=%0d gnt=%0d exp=1/1", rsp_idx_q.size(), gnt_q.size());
    end else begin
      checks++; if (rsp_idx_q[0] !== 3 || {rsp_z_q[0], rsp_err_q[0]} !== 2'b01) begin failures++; $display("FAIL timeout_rsp idx=%0d z=%b err=%b exp=3/0/1", rsp_idx_q[0], rsp_z_q[0], rsp_err_q[0]); end
      checks++; if ((rsp_cyc_q[0] - gnt_cyc_q[0]) !== 4 + TO) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", rsp_cyc_q[0] - gnt_cyc_q[0], 4 + TO); end
    end
    set_op(0, 32'h3F800000, 32'h40000000);
    bus.req_stb[0] = 1'b1;
    run_until_rsp(2, 60);
    step(); step();
    checks++;
    if (rsp_idx_q.size() != 2 || gnt_q.size() != 2) begin
      failures++; $display("FAIL timeout_next_count rsp=%0d gnt=%0d exp=2/2", rsp_idx_q.size(), gnt_q.size());
    end else begin
      checks++; if (rsp_idx_q[1] !== 0 || {rsp_z_q[1], rsp_err_q[1]} !== 2'b10) begin failures++; $display("FAIL timeout_next_rsp idx=%0d z=%b err=%b exp=0/1/0", rsp_idx_q[1], rsp_z_q[1], rsp_err_q[1]); end
      checks++; if ((rsp_cyc_q[1] - gnt_cyc_q[1]) !== 4 + LAT) begin failures++; $display("FAIL timeout_next_latency got=%0d exp=%0d", rsp_cyc_q[1] - gnt_cyc_q[1], 4 + LAT); end
    end
    checks++; if (crst_cnt !== 2) begin failures++; $display("FAIL timeout_cmp_rst_pulses got=%0d exp=2", crst_cnt); end
  endtask

  task automatic test_reset_mid();
    int t0;
    clear_logs();
    set_op(1, 32'h40000000, 32'h40400000);
    bus.req_stb[1] = 1'b1;
    for (int i = 0; i < 20 && gnt_q.size() < 1; i++) step();
    repeat (4) step();
    rst = 1'b1;
    #1;
    checks++; if (bus.cmp_rst !== 1'b1) begin failures++; $display("FAIL rstmid_cmp_rst_during got=%b exp=1", bus.cmp_rst); end
    step();
    checks++; if (bus.req_ack !== 4'b0 || bus.rsp_stb !== 4'b0) begin failures++; $display("FAIL rstmid_ack_stb got=%b/%b exp=0000/0000", bus.req_ack, bus.rsp_stb); end
    checks++; if ({bus.cmp_a_stb, bus.cmp_b_stb, bus.rsp_z, bus.rsp_err} !== 4'b0000) begin failures++; $display("FAIL rstmid_outputs got=%b%b%b%b exp=0000", bus.cmp_a_stb, bus.cmp_b_stb, bus.rsp_z, bus.rsp_err); end
    rst = 1'b0;
    repeat (15) step();
    checks++; if (rsp_idx_q.size() !== 0) begin failures++; $display("FAIL rstmid_dropped rsp_count=%0d exp=0", rsp_idx_q.size()); end
    t0 = cyc;
    bus.req_stb[1] = 1'b1;
    run_until_rsp(1, 40);
    step(); step();
    checks++;
    if (rsp_idx_q.size() != 1 || gnt_q.size() != 2) begin
      failures++; $display("FAIL rstmid_retry_count rsp=%0d gnt=%0d exp=1/2", rsp_idx_q.size(), gnt_q.size());
    end else begin
      checks++; if (gnt_q[1] !== 1 || (gnt_cyc_q[1] - t0) !== 1) begin failures++; $display("FAIL rstmid_retry_grant got=%0d delay=%0d exp=1/1", gnt_q[1], gnt_cyc_q[1] - t0); end
      checks++; if (rsp_idx_q[0] !== 1 || {rsp_z_q[0], rsp_err_q[0]} !== 2'b10) begin failures++; $display("FAIL rstmid_retry_rsp idx=%0d z=%b err=%b exp=1/1/0", rsp_idx_q[0], rsp_z_q[0], rsp_err_q[0]); end
      checks++; if ((rsp_cyc_q[0] - gnt_cyc_q[1]) !== 4 + LAT) begin failures++; $display("FAIL rstmid_retry_latency got=%0d exp=%0d", rsp_cyc_q[0] - gnt_cyc_q[1], 4 + LAT); end
    end
  endtask

  initial begin
    bus.req_stb = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.rsp_ack = '0;
    test_reset();
    test_single();
    test_all_same_cycle();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
